// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
// master: start, a, b, bin out; busy, done, diff, bout in. slave: reverse.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor cell.
// Ports: a, b, bin in; diff = a-b-bin bit, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave side of the bundle).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_nxt;
  logic             br;
  logic             bout_q;
  logic             d;
  logic             br_nxt;
  logic             last;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d),
    .bout (br_nxt)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write the current bit at position cnt; other bits keep their value.
  always_comb begin
    diff_nxt = diff_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) diff_nxt[i] = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= bus.bin;
            diff_q <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_nxt;
          diff_q <= diff_nxt;
          cnt    <= cnt + 1'b1;
          if (last) bout_q <= br_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN) || (state == DONE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Table vectors, hand sequences and random ops against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(1)) i1 ();

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (i8.slave)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (i1.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic bin);
    if (w == 1) begin
      i1.start = s; i1.a = a[0]; i1.b = b[0]; i1.bin = bin;
    end else begin
      i8.start = s; i8.a = a; i8.b = b; i8.bin = bin;
    end
  endtask

  function automatic logic dn(input int w);
    return (w == 1) ? i1.done : i8.done;
  endfunction

  function automatic logic [7:0] rdd(input int w);
    return (w == 1) ? {7'b0, i1.diff} : i8.diff;
  endfunction

  function automatic logic rdb(input int w);
    return (w == 1) ? i1.bout : i8.bout;
  endfunction

  // Reference: plain w-bit unsigned arithmetic.
  task automatic model(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, output logic [7:0] d,
                       output logic bo);
    int ai, bi, r;
    ai = (w == 1) ? int'(a[0]) : int'(a);
    bi = (w == 1) ? int'(b[0]) : int'(b);
    r  = ai - bi - int'(bin);
    bo = (ai < bi + int'(bin));
    if (r < 0) r += (1 << w);
    d = 8'(r);
  endtask

  // One full operation; inputs are scrambled right after acceptance.
  task automatic op(input int w, input logic [7:0] a, input logic [7:0] b,
                    input logic bin, output logic [7:0] d, output logic bo,
                    output int lat, output logic extra);
    drive(w, 1'b1, a, b, bin);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    lat = 1;
    while (!dn(w) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    d  = rdd(w);
    bo = rdb(w);
    @(negedge clk);
    extra = dn(w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, ed;
    logic       bo, ebo, ex;
    int         lat, nd, first, prev;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    tbl[4] = '{8'h37, 8'h37, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1;
    drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", i8.busy, 0);
    chk("rst_done", i8.done, 0);
    chk("rst_diff", i8.diff, 0);
    chk("rst_bout", i8.bout, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      op(8, tbl[i].a, tbl[i].b, tbl[i].bin, d, bo, lat, ex);
      chk($sformatf("tbl%0d_diff", i), d, tbl[i].d);
      chk($sformatf("tbl%0d_bout", i), bo, tbl[i].bo);
      chk($sformatf("tbl%0d_lat", i), lat, 9);
      chk($sformatf("tbl%0d_1cyc", i), ex, 0);
    end

    repeat (3) @(negedge clk);
    chk("hold_diff", i8.diff, 8'hFF);
    chk("hold_bout", i8.bout, 1);
    chk("hold_busy", i8.busy, 0);

    // Start pulsed while busy must be ignored.
    drive(8, 1'b1, 8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    drive(8, 1'b1, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    nd = 0;
    d  = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (i8.done) begin
        nd++;
        d = i8.diff;
      end
      @(negedge clk);
    end
    chk("busy_start_ndone", nd, 1);
    chk("busy_start_diff", d, 8'hFE);
    chk("busy_start_final", i8.diff, 8'hFE);

    // Reset on the 4th RUN edge, with start also high.
    drive(8, 1'b1, 8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(8, 1'b1, 8'h33, 8'h11, 1'b0);
    @(negedge clk);
    chk("abort_busy", i8.busy, 0);
    chk("abort_diff", i8.diff, 0);
    chk("abort_bout", i8.bout, 0);
    rst = 1'b0;
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (i8.done || i8.busy) nd++;
    end
    chk("abort_no_done", nd, 0);

    // Start held high: results every WIDTH+2 cycles.
    drive(8, 1'b1, 8'h80, 8'h01, 1'b0);
    nd = 0; first = -1; prev = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (i8.done) begin
        if (nd == 0) first = k;
        else chk($sformatf("held_period%0d", nd), k - prev, 10);
        chk($sformatf("held_diff%0d", nd), i8.diff, 8'h7F);
        chk($sformatf("held_bout%0d", nd), i8.bout, 0);
        prev = k;
        nd++;
      end
    end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("held_ndone", nd, 4);
    chk("held_first", first, 9);
    repeat (12) @(negedge clk);

    // WIDTH=1: all input combinations.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      model(1, {7'b0, vv[2]}, {7'b0, vv[1]}, vv[0], ed, ebo);
      op(1, {7'b0, vv[2]}, {7'b0, vv[1]}, vv[0], d, bo, lat, ex);
      chk($sformatf("w1_%0d_diff", v), d, ed);
      chk($sformatf("w1_%0d_bout", v), bo, ebo);
      chk($sformatf("w1_%0d_lat", v), lat, 2);
    end

    // WIDTH=8: random operands.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if (n % 16 == 0) rb = ra;
      model(8, ra, rb, rc, ed, ebo);
      op(8, ra, rb, rc, d, bo, lat, ex);
      if (d !== ed || bo !== ebo || lat != 9 || ex !== 1'b0)
        $display("FAIL rnd%0d: a=%0h b=%0h bin=%0b got %0h/%0b exp %0h/%0b",
                 n, ra, rb, rc, d, bo, ed, ebo);
      chk($sformatf("rnd%0d_diff", n), d, ed);
      chk($sformatf("rnd%0d_bout", n), bo, ebo);
      chk($sformatf("rnd%0d_lat", n), lat, 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 busy  output  1  high while in RUN or DONE.
REQ-009 done  output  1  one-cycle pulse; diff and bout are valid in that cycle.
REQ-010 diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL do all of the following on that edge: latch a, b and bin; clear diff; set bit counter to 0; enter RUN.
REQ-014 Each RUN edge SHALL process exactly one bit, LSB first (bit index equals the counter value).
REQ-015 The bit cell SHALL compute d = ai ^ bi ^ br and br_next = (~ai & bi) | (~(ai ^ bi) & br). The borrow register br is initialised from bin.
REQ-016 d SHALL be written into diff[counter]; br SHALL be updated to br_next.
REQ-017 On the RUN edge where counter = WIDTH-1, the state SHALL become DONE and bout SHALL be set to br_next.
REQ-018 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge, for exactly one cycle.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; it is not queued.
REQ-021 If start is held continuously, a new operation SHALL be accepted on the first IDLE edge. Throughput is one result per WIDTH+2 cycles.
REQ-022 diff and bout SHALL hold their last values in IDLE until the next accepting edge clears diff.
REQ-023 Changes on a, b or bin after the accepting edge SHALL NOT affect the result.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during RUN. For WIDTH=1, RUN lasts one edge.
REQ-025 done and busy SHALL be Moore outputs, decoded from the state register only.

Reset
REQ-026 When rst=1 on an edge, the block SHALL force all of the following: state=IDLE, counter=0, br=0, diff=0, bout=0, busy=0, done=0.
REQ-027 rst SHALL take priority over start and over any RUN or DONE activity.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-029 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-031 The one-bit cell SHALL be a separate combinational sub-module, full_subtractor, with ports a, b, bin, diff and bout.
REQ-032 The top level SHALL contain the FSM, the counter, the operand shift registers and the borrow register only.

Verification
REQ-033 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; done high exactly 8 edges after the accepting edge.
REQ-034 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Also a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
REQ-035 a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0. Then, while busy, pulse start with a=0x01, b=0x01: it is ignored, only one done occurs, and the result is unchanged.
REQ-036 Assert rst on the 4th RUN edge of a=0xAA, b=0x55 -> the next cycle shows busy=0, diff=0x00, bout=0, and no done pulse occurs.
REQ-037 Hold start=1 continuously with a=0x80, b=0x01 -> done pulses every 10 cycles, each time with diff=0x7F, bout=0.
REQ-038 Run an exhaustive random check for WIDTH=1 and WIDTH=8 against the reference model {bout,diff} = a - b - bin (WIDTH+1-bit two's complement).
